coin_dispenser_ctrl: RTL and testbench
======================================

COIN_DISPENSER_CTRL -- requirements
Module: coin_dispenser_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  TIMEOUT  16  cycles allowed in WAIT_ACK for a coin-sensor acknowledge (range 2..255)
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clock      in   1   single clock, all logic on rising edge
  reset_n    in   1   synchronous, active-low reset
  req_valid  in   1   change request present
  req_ready  out  1   high only in IDLE
  req_n100   in   8   count of 100-unit coins to dispense
  req_n50    in   8   count of 50-unit coins
  req_n25    in   8   count of 25-unit coins
  eject      out  1   one-cycle pulse that fires the coin solenoid
  eject_sel  out  2   denomination for eject: 0=25, 1=50, 2=100, 3 never driven
  coin_seen  in   1   coin-sensor pulse confirming a coin left the chute
  clear      in   1   leaves FAULT
  done       out  1   one-cycle pulse on successful completion
  error      out  1   high while in FAULT
  paid_value out  16  running value dispensed for the current request

Function
REQ-003 The FSM SHALL have the states IDLE, SELECT, EJECT, WAIT_ACK, DONE and FAULT.
REQ-004 A request SHALL be accepted on the edge where req_valid && req_ready.
  - Accept latches the three counts into remaining registers.
  - Accept clears paid_value to 0.
  - Accept moves the FSM to SELECT.
REQ-005 SELECT SHALL take exactly one cycle.
  - All remaining counts zero: go to DONE.
  - Otherwise pick the highest nonzero denomination (100, then 50, then 25) and go to EJECT.
REQ-006 EJECT SHALL assert eject=1 for exactly one cycle, with eject_sel valid in the same cycle.
  - EJECT then goes to WAIT_ACK with the timer at 0.
  - eject_sel holds its value through WAIT_ACK.
REQ-007 WAIT_ACK behaviour:
  - coin_seen=1: decrement the selected remaining count, add 25/50/100 to paid_value, go to SELECT.
  - Otherwise: increment the timer.
  - Timer == TIMEOUT-1 without coin_seen: go to FAULT.
REQ-008 If coin_seen and timer expiry occur in the same cycle, coin_seen SHALL win.
REQ-009 coin_seen SHALL be ignored in every state except WAIT_ACK.
REQ-010 DONE SHALL assert done=1 for one cycle and then go to IDLE.
REQ-011 FAULT behaviour:
  - error=1 and eject=0.
  - Remaining counts and paid_value are held.
  - clear=1 goes to IDLE and zeroes the remaining counts.
  - paid_value keeps its value until the next accept.
REQ-012 An all-zero request SHALL give done exactly 2 cycles after accept, with no eject.
REQ-013 Per coin, the cost SHALL be 3 cycles + ack latency; eject pulses SHALL be at least 3 cycles apart.
REQ-014 paid_value SHALL be 16-bit unsigned and SHALL NOT overflow (maximum 255*175 = 44625).
REQ-015 req_valid while not in IDLE SHALL have no effect.
REQ-016 clear outside FAULT SHALL have no effect.

Reset
REQ-017 When reset_n=0 on a rising edge:
  - FSM goes to IDLE.
  - remaining counts, timer and paid_value go to 0.
  - eject=0, eject_sel=0, done=0, error=0.
  - req_ready goes to 1 on the first edge with reset_n=1.
REQ-018 Reset mid-dispense SHALL abort immediately with no further eject.

Structure
REQ-019 A shared package SHALL hold:
  - the state enum;
  - the denomination encoding 0/1/2;
  - the denomination values 25/50/100;
  - the paid_value width constant.
REQ-020 One sub-module, coin_ack_timer, SHALL hold the WAIT_ACK timer (inputs: start, tick_enable; output: expired).

Verification
REQ-021 Req 100/50/25 counts = 1/1/1, coin_seen 2 cycles after each eject:
  - eject_sel order is 2, 1, 0;
  - paid_value = 175;
  - done is pulsed once.
REQ-022 Req 0/0/0 -> done 2 cycles after accept, eject never asserted, paid_value = 0.
REQ-023 Req n25=2, coin_seen withheld after the second eject with TIMEOUT=16:
  - error rises 16 cycles after WAIT_ACK entry;
  - paid_value = 25;
  - clear -> IDLE, req_ready=1.
REQ-024 coin_seen on the timer-expiry cycle -> no FAULT, the count decrements and dispensing continues.
REQ-025 reset_n=0 during WAIT_ACK of req n50=3 -> the next cycle is IDLE, all outputs 0, no further eject.
REQ-026 Spurious coin_seen in IDLE, and req_valid while busy -> paid_value and the remaining counts are unchanged.

Source files
------------

// File: rtl/coin_dispenser_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// coin_dispenser_ctrl_pkg
// Shared definitions for the coin dispenser controller: FSM state encoding,
// denomination encoding (as driven on eject_sel), denomination values, and
// the datapath widths. denom_value() maps a denomination code to its value.
// -----------------------------------------------------------------------------
package coin_dispenser_ctrl_pkg;

  // Width of the running paid total; 255 coins of each kind peak at 44625.
  localparam int unsigned PAID_W  = 16;
  // Width of each per-denomination coin count.
  localparam int unsigned COUNT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SELECT   = 3'd1,
    ST_EJECT    = 3'd2,
    ST_WAIT_ACK = 3'd3,
    ST_DONE     = 3'd4,
    ST_FAULT    = 3'd5
  } state_t;

  // Code 3 is never produced.
  typedef enum logic [1:0] {
    DENOM_25  = 2'd0,
    DENOM_50  = 2'd1,
    DENOM_100 = 2'd2
  } denom_t;

  localparam logic [PAID_W-1:0] VALUE_25  = 16'd25;
  localparam logic [PAID_W-1:0] VALUE_50  = 16'd50;
  localparam logic [PAID_W-1:0] VALUE_100 = 16'd100;

  function automatic logic [PAID_W-1:0] denom_value(input denom_t d);
    logic [PAID_W-1:0] v;
    case (d)
      DENOM_25:  v = VALUE_25;
      DENOM_50:  v = VALUE_50;
      DENOM_100: v = VALUE_100;
      default:   v = 16'd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/coin_dispenser_ctrl_if.sv
// -----------------------------------------------------------------------------
// coin_dispenser_ctrl_if
// Bundles the request handshake, solenoid/sensor and status signals of the
// coin dispenser controller.
//   master : requester / machine side (drives request, coin_seen, clear)
//   slave  : controller side (drives req_ready, eject, eject_sel, done,
//            error, paid_value)
// -----------------------------------------------------------------------------
interface coin_dispenser_ctrl_if;
  import coin_dispenser_ctrl_pkg::*;

  logic               req_valid;
  logic               req_ready;
  logic [COUNT_W-1:0] req_n100;
  logic [COUNT_W-1:0] req_n50;
  logic [COUNT_W-1:0] req_n25;
  logic               eject;
  logic [1:0]         eject_sel;
  logic               coin_seen;
  logic               clear;
  logic               done;
  logic               error;
  logic [PAID_W-1:0]  paid_value;

  modport master (
    output req_valid, req_n100, req_n50, req_n25, coin_seen, clear,
    input  req_ready, eject, eject_sel, done, error, paid_value
  );

  modport slave (
    input  req_valid, req_n100, req_n50, req_n25, coin_seen, clear,
    output req_ready, eject, eject_sel, done, error, paid_value
  );

endinterface

// File: rtl/coin_dispenser_ctrl_ack_timer.sv
// -----------------------------------------------------------------------------
// coin_ack_timer
// Counts WAIT_ACK cycles while the controller waits for the coin sensor.
//   clock, reset_n : clock and synchronous active-low reset
//   start          : clear the count (issued while ejecting a coin)
//   tick_enable    : advance the count by one
//   expired        : count has reached TIMEOUT-1 (registered)
// -----------------------------------------------------------------------------
module coin_ack_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic start,
  input  logic tick_enable,
  output logic expired
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 32'd1);

  logic [7:0] count_r;
  logic [7:0] count_s;
  logic       expired_r;

  // Next count: restart on start, otherwise advance without passing LAST.
  always_comb begin
    count_s = count_r;
    if (start) begin
      count_s = 8'd0;
    end else if (tick_enable && (count_r != LAST)) begin
      count_s = count_r + 8'd1;
    end else begin
      count_s = count_r;
    end
  end

  // Count register and expiry flag, flag computed from the next count so it
  // lines up with the count it describes.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count_r   <= 8'd0;
      expired_r <= 1'b0;
    end else begin
      count_r   <= count_s;
      expired_r <= (count_s == LAST);
    end
  end

  assign expired = expired_r;

endmodule

// File: rtl/coin_dispenser_ctrl.sv
// -----------------------------------------------------------------------------
// coin_dispenser_ctrl
// Dispenses a requested mix of 100/50/25 coins one at a time, largest first,
// waiting for a coin-sensor acknowledge after each solenoid pulse and
// faulting if none arrives within TIMEOUT cycles.
//   clock   : rising-edge clock
//   reset_n : synchronous active-low reset
//   bus     : slave side of coin_dispenser_ctrl_if (request handshake,
//             eject/eject_sel, coin_seen, clear, done, error, paid_value)
// All status outputs are registered and decoded from the next state, so they
// are valid throughout the cycle of the state they describe.
// -----------------------------------------------------------------------------
module coin_dispenser_ctrl
  import coin_dispenser_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  coin_dispenser_ctrl_if.slave bus
);

  state_t             state_r;
  state_t             state_s;
  logic [COUNT_W-1:0] rem100_r;
  logic [COUNT_W-1:0] rem50_r;
  logic [COUNT_W-1:0] rem25_r;
  logic [COUNT_W-1:0] rem100_s;
  logic [COUNT_W-1:0] rem50_s;
  logic [COUNT_W-1:0] rem25_s;
  denom_t             sel_r;
  denom_t             sel_s;
  logic [PAID_W-1:0]  paid_r;
  logic [PAID_W-1:0]  paid_s;
  logic               ready_r;
  logic               eject_r;
  logic               done_r;
  logic               error_r;
  logic               timer_start_s;
  logic               timer_tick_s;
  logic               timer_expired_s;

  coin_ack_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_ack_timer (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (timer_start_s),
    .tick_enable(timer_tick_s),
    .expired    (timer_expired_s)
  );

  // Next-state and datapath update logic.
  always_comb begin
    state_s       = state_r;
    rem100_s      = rem100_r;
    rem50_s       = rem50_r;
    rem25_s       = rem25_r;
    sel_s         = sel_r;
    paid_s        = paid_r;
    timer_start_s = 1'b0;
    timer_tick_s  = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (bus.req_valid && ready_r) begin
          rem100_s = bus.req_n100;
          rem50_s  = bus.req_n50;
          rem25_s  = bus.req_n25;
          paid_s   = 16'd0;
          state_s  = ST_SELECT;
        end else begin
          state_s  = ST_IDLE;
        end
      end

      ST_SELECT: begin
        // Largest denomination with coins left goes next.
        if (rem100_r != 8'd0) begin
          sel_s   = DENOM_100;
          state_s = ST_EJECT;
        end else if (rem50_r != 8'd0) begin
          sel_s   = DENOM_50;
          state_s = ST_EJECT;
        end else if (rem25_r != 8'd0) begin
          sel_s   = DENOM_25;
          state_s = ST_EJECT;
        end else begin
          state_s = ST_DONE;
        end
      end

      ST_EJECT: begin
        timer_start_s = 1'b1;
        state_s       = ST_WAIT_ACK;
      end

      ST_WAIT_ACK: begin
        // An acknowledge on the expiry cycle still counts as a good coin.
        if (bus.coin_seen) begin
          case (sel_r)
            DENOM_100: rem100_s = rem100_r - 8'd1;
            DENOM_50:  rem50_s  = rem50_r - 8'd1;
            DENOM_25:  rem25_s  = rem25_r - 8'd1;
            default:   rem25_s  = rem25_r;
          endcase
          paid_s  = paid_r + denom_value(sel_r);
          state_s = ST_SELECT;
        end else if (timer_expired_s) begin
          state_s = ST_FAULT;
        end else begin
          timer_tick_s = 1'b1;
          state_s      = ST_WAIT_ACK;
        end
      end

      ST_DONE: begin
        state_s = ST_IDLE;
      end

      ST_FAULT: begin
        // paid_value is kept for inspection until the next request.
        if (bus.clear) begin
          rem100_s = 8'd0;
          rem50_s  = 8'd0;
          rem25_s  = 8'd0;
          state_s  = ST_IDLE;
        end else begin
          state_s  = ST_FAULT;
        end
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Remaining counts, selected denomination and paid total.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rem100_r <= 8'd0;
      rem50_r  <= 8'd0;
      rem25_r  <= 8'd0;
      sel_r    <= DENOM_25;
      paid_r   <= 16'd0;
    end else begin
      rem100_r <= rem100_s;
      rem50_r  <= rem50_s;
      rem25_r  <= rem25_s;
      sel_r    <= sel_s;
      paid_r   <= paid_s;
    end
  end

  // Registered status outputs decoded from the next state; req_ready stays
  // low for the reset cycles and rises on the first edge out of reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ready_r <= 1'b0;
      eject_r <= 1'b0;
      done_r  <= 1'b0;
      error_r <= 1'b0;
    end else begin
      ready_r <= (state_s == ST_IDLE);
      eject_r <= (state_s == ST_EJECT);
      done_r  <= (state_s == ST_DONE);
      error_r <= (state_s == ST_FAULT);
    end
  end

  assign bus.req_ready  = ready_r;
  assign bus.eject      = eject_r;
  assign bus.eject_sel  = sel_r;
  assign bus.done       = done_r;
  assign bus.error      = error_r;
  assign bus.paid_value = paid_r;

endmodule

// File: tb/tb_coin_dispenser_ctrl.sv
// -----------------------------------------------------------------------------
// tb_coin_dispenser_ctrl
// Scoreboard bench: each request is turned into a timeline of expected
// events (eject pulses, done, error, ready rising, sampled values) from the
// coin-cost rules; a monitor compares everything the DUT presents.
// -----------------------------------------------------------------------------
module tb_coin_dispenser_ctrl;
  import coin_dispenser_ctrl_pkg::*;

  localparam int TIMEOUT = 16;

  typedef enum int {EV_EJECT, EV_DONE, EV_ERROR, EV_READY, EV_PAID, EV_SEL, EV_ZERO} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       val;
    int       cyc;
  } ev_t;

  logic clock = 1'b0;
  logic reset_n;
  coin_dispenser_ctrl_if bus();

  coin_dispenser_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  ev_t sbq[$];
  int  checks = 0;
  int  errors = 0;
  int  coin_val[3] = '{25, 50, 100};
  int  ack_q[$];
  int  wlo_q[$];
  int  whi_q[$];
  logic err_q = 1'b0;
  logic rdy_q = 1'b0;

  // ---------------- monitor ----------------
  task automatic drop_overdue();
    ev_t e;
    while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
      e = sbq.pop_front();
      checks++;
      errors++;
      $display("FAIL missed_%s: got nothing, required value %0d at cycle %0d", e.kind.name(), e.val, e.cyc);
    end
  endtask

  task automatic do_levels();
    ev_t e;
    int  act;
    while (sbq.size() > 0 && sbq[0].cyc == cyc && sbq[0].kind inside {EV_PAID, EV_SEL, EV_ZERO}) begin
      e = sbq.pop_front();
      case (e.kind)
        EV_PAID: act = int'(bus.paid_value);
        EV_SEL:  act = int'(bus.eject_sel);
        default: act = int'({bus.eject, bus.done, bus.error, bus.req_ready, bus.eject_sel, bus.paid_value});
      endcase
      checks++;
      if (act != e.val) begin
        errors++;
        $display("FAIL %s: got %0d required %0d at cycle %0d", e.kind.name(), act, e.val, cyc);
      end
    end
  endtask

  task automatic take_pulse(input ev_kind_t k, input int v);
    ev_t e;
    checks++;
    if (sbq.size() == 0 || sbq[0].cyc != cyc) begin
      errors++;
      $display("FAIL unexpected_%s: got event value %0d at cycle %0d, required no event", k.name(), v, cyc);
    end else begin
      e = sbq.pop_front();
      if (e.kind != k) begin
        errors++;
        $display("FAIL event_kind: got %s required %s at cycle %0d", k.name(), e.kind.name(), cyc);
      end else if (v != e.val) begin
        errors++;
        $display("FAIL %s_value: got %0d required %0d at cycle %0d", k.name(), v, e.val, cyc);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clock);
      drop_overdue();
      do_levels();
      if (bus.eject === 1'b1) take_pulse(EV_EJECT, int'(bus.eject_sel));
      if (bus.done === 1'b1) take_pulse(EV_DONE, int'(bus.paid_value));
      if (bus.error === 1'b1 && !err_q) take_pulse(EV_ERROR, int'(bus.paid_value));
      if (bus.req_ready === 1'b1 && !rdy_q) take_pulse(EV_READY, int'(bus.paid_value));
      err_q = (bus.error === 1'b1);
      rdy_q = (bus.req_ready === 1'b1);
      do_levels();
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input ev_kind_t k, input int v, input int c);
    ev_t e;
    e.kind = k;
    e.val  = v;
    e.cyc  = c;
    sbq.push_back(e);
  endtask

  task automatic drive_idle();
    bus.req_valid = 1'b0;
    bus.req_n100  = 8'd0;
    bus.req_n50   = 8'd0;
    bus.req_n25   = 8'd0;
    bus.coin_seen = 1'b0;
    bus.clear     = 1'b0;
  endtask

  function automatic bit is_ack(input int c);
    foreach (ack_q[i]) if (ack_q[i] == c) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit in_wait(input int c);
    foreach (wlo_q[i]) if (c >= wlo_q[i] && c <= whi_q[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic wait_ready();
    int guard = 0;
    while (bus.req_ready !== 1'b1 && guard < 64) begin
      step();
      guard++;
    end
  endtask

  // One request: each coin costs 3 cycles plus its ack latency, largest first.
  task automatic run_req(input int n100, input int n50, input int n25,
                         input int fail_at, input int fix_lat, input bit noise);
    int sel_q[$];
    int k, t, e, l, ack, paid, endc, vlim, f, h, g;
    bit faulted;
    ack_q.delete(); wlo_q.delete(); whi_q.delete();
    for (int i = 0; i < n100; i++) sel_q.push_back(2);
    for (int i = 0; i < n50; i++) sel_q.push_back(1);
    for (int i = 0; i < n25; i++) sel_q.push_back(0);
    wait_ready();
    drive_idle();
    k = cyc;
    bus.req_valid = 1'b1;
    bus.req_n100  = 8'(n100);
    bus.req_n50   = 8'(n50);
    bus.req_n25   = 8'(n25);
    t = k + 2; paid = 0; faulted = 1'b0; f = 0;
    foreach (sel_q[j]) begin
      e = t;
      push(EV_EJECT, sel_q[j], e);
      if (j == fail_at) begin
        f = e + TIMEOUT + 1;
        push(EV_ERROR, paid, f);
        wlo_q.push_back(e + 1); whi_q.push_back(f - 1);
        faulted = 1'b1;
        break;
      end
      l   = (fix_lat >= 0) ? fix_lat : int'($urandom_range(0, TIMEOUT - 1));
      ack = e + 1 + l;
      push(EV_SEL, sel_q[j], ack);
      ack_q.push_back(ack); wlo_q.push_back(e + 1); whi_q.push_back(ack);
      paid += coin_val[sel_q[j]];
      t = ack + 2;
    end
    if (!faulted) begin
      push(EV_DONE, paid, t);
      push(EV_READY, paid, t + 1);
      endc = t + 1; vlim = t;
    end else begin
      endc = f; vlim = f;
    end
    while (cyc < endc) begin
      step();
      bus.req_valid = noise && (cyc < vlim) && ($urandom_range(0, 2) == 0);
      bus.req_n100  = 8'($urandom_range(0, 255));
      bus.req_n50   = 8'($urandom_range(0, 255));
      bus.req_n25   = 8'($urandom_range(0, 255));
      bus.coin_seen = is_ack(cyc) || (noise && !in_wait(cyc) && ($urandom_range(0, 1) == 0));
      bus.clear     = noise && !(faulted && cyc >= f) && ($urandom_range(0, 3) == 0);
    end
    if (faulted) begin
      h = $urandom_range(0, 3);
      for (int i = 0; i < h; i++) begin
        step();
        drive_idle();
        bus.coin_seen = ($urandom_range(0, 1) == 0);
        push(EV_PAID, paid, cyc);
      end
      step();
      drive_idle();
      bus.clear = 1'b1;
      push(EV_READY, paid, cyc + 1);
      step();
      drive_idle();
    end else begin
      g = $urandom_range(1, 4);
      for (int i = 0; i < g; i++) begin
        step();
        drive_idle();
        bus.coin_seen = noise && ($urandom_range(0, 1) == 0);
        bus.clear     = noise && ($urandom_range(0, 1) == 0);
        push(EV_PAID, paid, cyc);
      end
      drive_idle();
    end
  endtask

  // Three 50s; reset lands while waiting for the second coin's acknowledge.
  task automatic run_reset_mid();
    int k, e0, ack0, e1, r;
    wait_ready();
    drive_idle();
    k = cyc;
    bus.req_valid = 1'b1;
    bus.req_n50   = 8'd3;
    e0   = k + 2;
    ack0 = e0 + 1 + int'($urandom_range(0, 4));
    e1   = ack0 + 2;
    r    = e1 + 1 + int'($urandom_range(0, 5));
    push(EV_EJECT, 1, e0);
    push(EV_SEL, 1, ack0);
    push(EV_EJECT, 1, e1);
    push(EV_ZERO, 0, r + 1);
    push(EV_ZERO, 0, r + 2);
    push(EV_READY, 0, r + 3);
    while (cyc < r + 3) begin
      step();
      drive_idle();
      bus.coin_seen = (cyc == ack0);
      reset_n = !(cyc >= r && cyc <= r + 1);
    end
    drive_idle();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int a, b, c, fa;
    reset_n = 1'b0;
    drive_idle();
    step();
    push(EV_ZERO, 0, cyc);
    step();
    push(EV_ZERO, 0, cyc);
    reset_n = 1'b1;
    push(EV_READY, 0, cyc + 1);
    step();

    run_req(1, 1, 1, -1, 1, 1'b0);
    run_req(0, 0, 0, -1, -1, 1'b0);
    run_req(0, 0, 2, 1, -1, 1'b0);
    run_req(1, 1, 1, -1, TIMEOUT - 1, 1'b0);
    run_reset_mid();
    run_req(2, 0, 1, -1, -1, 1'b1);
    for (int n = 0; n < 12; n++) begin
      a = $urandom_range(0, 3);
      b = $urandom_range(0, 3);
      c = $urandom_range(0, 3);
      fa = -1;
      if ((a + b + c) > 0 && $urandom_range(0, 4) == 0) fa = $urandom_range(0, a + b + c - 1);
      run_req(a, b, c, fa, -1, 1'b1);
    end
    repeat (25) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so a stuck run still ends with a report line.
  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1);
  end

endmodule
